// File: rtl/soc_mem_scrub_master.sv
// Avalon-MM fill/check engine: writes a constant or incrementing pattern over a region, or reads it back with checksum/mismatch count.
// One word per cycle on fill, two per word on check (plus slave latency); every waitrequest cycle holds the request and adds one cycle.
module soc_mem_scrub_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      incr,
    input  logic [ADDR_WIDTH-1:0]     base,
    input  logic [ADDR_WIDTH:0]       length,
    input  logic [DATA_WIDTH-1:0]     seed,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     checksum,
    output logic [ADDR_WIDTH:0]       err_count,
    output logic [ADDR_WIDTH-1:0]     first_err_addr,
    output logic                      err_flag,
    output logic [ADDR_WIDTH-1:0]     avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATA_WIDTH-1:0]     avm_writedata,
    output logic [DATA_WIDTH/8-1:0]   avm_byteenable,
    input  logic                      avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]     avm_readdata,
    input  logic                      avm_readdatavalid
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH:0]     idx;
    logic [ADDR_WIDTH:0]     len_q;
    logic                    incr_q;
    logic                    abort_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   pat_q;

    logic last_word;
    logic stop;
    logic wr_acc;
    logic rd_ret;

    assign last_word = ((idx + CNT_ONE) == len_q);
    // abort is honoured only here, i.e. after a transfer has fully completed
    assign stop      = last_word | abort_q | abort;
    assign wr_acc    = (state == WR) && !avm_waitrequest;
    assign rd_ret    = (state == RWAIT) && avm_readdatavalid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        state_nxt = DONE;
                    else if (mode)
                        state_nxt = RD;
                    else
                        state_nxt = WR;
                end
            end
            WR: begin
                if (!avm_waitrequest)
                    state_nxt = stop ? DONE : WR;
            end
            RD: begin
                if (!avm_waitrequest)
                    state_nxt = RWAIT;
            end
            RWAIT: begin
                if (avm_readdatavalid)
                    state_nxt = stop ? DONE : RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            len_q          <= '0;
            incr_q         <= 1'b0;
            abort_q        <= 1'b0;
            addr_q         <= '0;
            pat_q          <= '0;
            checksum       <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                idx            <= '0;
                len_q          <= length;
                incr_q         <= incr;
                abort_q        <= 1'b0;
                addr_q         <= base;
                pat_q          <= seed;
                checksum       <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else begin
                if (state != IDLE && abort)
                    abort_q <= 1'b1;
                if (wr_acc || rd_ret) begin
                    idx    <= idx + CNT_ONE;
                    addr_q <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    pat_q  <= pat_q + {{(DATA_WIDTH-1){1'b0}}, incr_q};
                end
                if (rd_ret) begin
                    checksum <= checksum + avm_readdata;
                    if (avm_readdata != pat_q) begin
                        if (err_count != '1)
                            err_count <= err_count + CNT_ONE;
                        if (err_count == '0)
                            first_err_addr <= addr_q;
                    end
                end
            end
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign avm_write      = (state == WR);
    assign avm_read       = (state == RD);
    assign avm_address    = addr_q;
    assign avm_writedata  = pat_q;
    assign avm_byteenable = '1;
    assign err_flag       = (err_count != '0);

endmodule

// File: tb/tb_soc_mem_scrub_master.sv
// Bench for soc_mem_scrub_master: Avalon slave with memory, stall/latency injection, pattern reference model and scoreboard.
module tb_soc_mem_scrub_master;

    localparam int AW = 15;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic              incr;
    logic [AW-1:0]     base;
    logic [AW:0]       length;
    logic [DW-1:0]     seed;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DW-1:0]     checksum;
    logic [AW:0]       err_count;
    logic [AW-1:0]     first_err_addr;
    logic              err_flag;
    logic [AW-1:0]     avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DW-1:0]     avm_writedata;
    logic [DW/8-1:0]   avm_byteenable;
    logic              avm_waitrequest;
    logic [DW-1:0]     avm_readdata;
    logic              avm_readdatavalid;

    always #5 clk = ~clk;

    soc_mem_scrub_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .incr              (incr),
        .base              (base),
        .length            (length),
        .seed              (seed),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .checksum          (checksum),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .err_flag          (err_flag),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [DW-1:0] cks;
        logic [AW:0]   errc;
        logic [AW-1:0] fea;
        int            n;
    } res_t;

    wr_t  exp_wr_q[$];
    res_t exp_res_q[$];

    logic [DW-1:0] mem     [0:32767];
    logic [DW-1:0] ref_mem [0:32767];

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int stall_cnt  = 0;
    int lat_sum    = 0;
    int req_idx    = 0;
    int stall_at   = -1;
    int stall_left = 0;
    bit rand_stall = 0;
    bit rand_lat   = 0;
    bit done_seen  = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - start_cyc);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_write", avm_write, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err_addr", first_err_addr, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_avm_writedata", avm_writedata, 0);
        chk("rst_byteenable", avm_byteenable, 4'hF);
    endtask

    // Slave: memory, injected stalls, read latency; also checks writes and stall stability.
    initial begin
        int            cd;
        bit            pend;
        bit            prev_st;
        logic [AW-1:0] ra;
        logic [48:0]   saved;
        cd = 0; pend = 0; prev_st = 0; ra = '0; saved = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (pend) begin
                if (cd <= 1) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = mem[ra];
                    pend = 0;
                end else begin
                    cd--;
                end
            end
            avm_waitrequest = 1'b0;
            if (avm_read || avm_write) begin
                if (req_idx == stall_at && stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                    avm_waitrequest = 1'b1;
                end
            end else if (rand_stall) begin
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (reset) begin
                pend = 0;
                prev_st = 0;
            end else begin
                if (prev_st)
                    chk("stall_hold", {avm_read, avm_write, avm_address, avm_writedata}, saved);
                if (avm_read && avm_write)
                    chk("strobes_exclusive", 1, 0);
                prev_st = (avm_read || avm_write) && avm_waitrequest;
                if (prev_st) begin
                    saved = {avm_read, avm_write, avm_address, avm_writedata};
                    stall_cnt++;
                end
                if (avm_write && !avm_waitrequest) begin
                    mem[avm_address] = avm_writedata;
                    req_idx++;
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write_addr", avm_address, 'h1_0000);
                    end else begin
                        wr_t w;
                        w = exp_wr_q.pop_front();
                        chk("wr_addr", avm_address, w.a);
                        chk("wr_data", avm_writedata, w.d);
                        chk("wr_byteenable", avm_byteenable, 4'hF);
                    end
                end
                if (avm_read && !avm_waitrequest) begin
                    pend = 1;
                    ra   = avm_address;
                    cd   = rand_lat ? $urandom_range(1, 3) : 1;
                    lat_sum += cd;
                    req_idx++;
                end
            end
        end
    end

    // Completion monitor: pops the expected result whenever done pulses.
    initial forever begin
        @(negedge clk);
        if (!reset && done) begin
            done_seen = 1;
            if (exp_res_q.size() == 0) begin
                chk("unexpected_done", done, 0);
            end else begin
                res_t r;
                r = exp_res_q.pop_front();
                chk("checksum", checksum, r.cks);
                chk("err_count", err_count, r.errc);
                chk("first_err_addr", first_err_addr, r.fea);
                chk("err_flag", err_flag, (r.errc != 0) ? 1 : 0);
                chk("done_cycle", cyc - start_cyc, 1 + r.n + stall_cnt + lat_sum);
            end
        end
    end

    // Reference model: n_eff words of the command actually transferred.
    task automatic issue(input bit m, input bit inc, input logic [AW-1:0] b,
                         input logic [AW:0] len, input logic [DW-1:0] s, input int n_eff);
        res_t r;
        r.cks = '0; r.errc = '0; r.fea = '0; r.n = n_eff;
        for (int i = 0; i < n_eff; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] p;
            a = b + AW'(i);
            p = inc ? s + DW'(i) : s;
            if (!m) begin
                exp_wr_q.push_back('{a, p});
                ref_mem[a] = p;
            end else begin
                r.cks = r.cks + ref_mem[a];
                if (ref_mem[a] != p) begin
                    if (r.errc == 0) r.fea = a;
                    if (r.errc != '1) r.errc = r.errc + 1;
                end
            end
        end
        exp_res_q.push_back(r);
        @(posedge clk);
        #1;
        stall_cnt = 0; lat_sum = 0; req_idx = 0; done_seen = 0;
        mode = m; incr = inc; base = b; length = len; seed = s;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 1'($urandom); incr = 1'($urandom); base = AW'($urandom);
        length = (AW+1)'($urandom); seed = $urandom;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && !done_seen; k++)
            @(posedge clk);
        if (!done_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within 3000 cycles");
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("writes_outstanding", exp_wr_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; incr = 1'b0;
        base = '0; length = '0; seed = '0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // abort while idle must not leak into the next command
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;

        issue(0, 1, 15'h010, 4, 32'h100, 4);
        wait_done();
        issue(1, 1, 15'h010, 4, 32'h100, 4);
        wait_done();
        chk("checksum_literal", checksum, 32'h406);

        mem[15'h012] = 32'hDEAD; ref_mem[15'h012] = 32'hDEAD;
        mem[15'h013] = 32'h55;   ref_mem[15'h013] = 32'h55;
        issue(1, 1, 15'h010, 4, 32'h100, 4);
        wait_done();

        stall_at = 1; stall_left = 3;
        issue(0, 1, 15'h100, 3, 32'hA5A5_0000, 3);
        wait_done();
        stall_at = -1;

        // wrap, with a start pulse while busy that must be ignored
        issue(0, 1, 15'h7FFE, 4, 32'h1234, 4);
        start = 1'b1; mode = 1'b1; length = 1;
        @(posedge clk); #1; start = 1'b0;
        wait_done();
        issue(1, 1, 15'h7FFE, 4, 32'h1234, 4);
        wait_done();

        issue(0, 1, 15'h005, 0, 32'h0, 0);
        wait_done();
        issue(1, 0, 15'h006, 0, 32'h0, 0);
        wait_done();

        issue(0, 0, 15'h200, 5, 32'hCAFE, 5);
        wait_done();
        issue(1, 0, 15'h200, 5, 32'hCAFF, 5);
        wait_done();

        // abort during a stalled read: that read still completes and is checked
        stall_at = 0; stall_left = 5;
        issue(1, 1, 15'h300, 8, 32'h0, 1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        wait_done();
        stall_at = -1;

        issue(0, 1, 15'h400, 10, 32'h77, 3);
        @(posedge clk); #1;
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        wait_done();

        // reset mid-fill
        issue(0, 1, 15'h500, 10, 32'h900, 10);
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check_reset_vals();
        exp_wr_q.delete();
        exp_res_q.delete();
        issue(0, 1, 15'h500, 5, 32'h900, 5);
        wait_done();
        issue(1, 1, 15'h500, 5, 32'h900, 5);
        wait_done();

        rand_stall = 1; rand_lat = 1;
        begin
            logic [AW-1:0] lb;
            logic [AW:0]   ll;
            logic [DW-1:0] ls;
            bit            li;
            lb = '0; ll = '0; ls = '0; li = 0;
            for (int t = 0; t < 25; t++) begin
                bit            m;
                bit            inc;
                logic [AW-1:0] b;
                logic [AW:0]   len;
                logic [DW-1:0] s;
                m   = 1'($urandom_range(0, 1));
                inc = 1'($urandom_range(0, 1));
                b   = AW'($urandom);
                len = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, 40));
                s   = $urandom;
                if (m && ll != 0 && $urandom_range(0, 1) == 1) begin
                    b = lb; len = ll; s = ls; inc = li;
                end
                if (!m) begin
                    lb = b; ll = len; ls = s; li = inc;
                end
                issue(m, inc, b, len, s, int'(len));
                wait_done();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
